// File: rtl/cache_refill_ctrl.sv
// Refill / write-through controller behind a direct-mapped, one-word-per-line data cache.
// Load misses fetch from memory and return a fill. Stores always write through to memory.
module cache_refill_ctrl #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    input  logic                  req_write_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic                  cache_hit_i,
    output logic                  stall_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ready_i,
    output logic                  fill_valid_o,
    output logic [ADDR_WIDTH-1:0] fill_addr_o,
    output logic [DATA_WIDTH-1:0] fill_data_o,
    output logic [CNT_WIDTH-1:0]  hit_cnt_o,
    output logic [CNT_WIDTH-1:0]  miss_cnt_o,
    output logic                  err_o
);

    localparam int unsigned TMO_WIDTH = $clog2(TIMEOUT);
    localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_FILL,
        S_DONE
    } state_e;

    state_e                  state_q,     state_d;
    logic [ADDR_WIDTH-1:0]   addr_q,      addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q,     wdata_d;
    logic [DATA_WIDTH-1:0]   fill_data_q, fill_data_d;
    logic                    st_hit_q,    st_hit_d;
    logic [TMO_WIDTH-1:0]    tmo_q,       tmo_d;
    logic                    err_q,       err_d;
    logic [CNT_WIDTH-1:0]    hit_cnt_q,   hit_cnt_d;
    logic [CNT_WIDTH-1:0]    miss_cnt_q,  miss_cnt_d;

    // Byte-offset bits are dropped: memory and the cache are word addressed.
    logic unused_byte_offset;
    assign unused_byte_offset = ^req_addr_i[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            fill_data_q <= '0;
            st_hit_q    <= 1'b0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            fill_data_q <= fill_data_d;
            st_hit_q    <= st_hit_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        fill_data_d = fill_data_q;
        st_hit_d    = st_hit_q;
        tmo_d       = tmo_q;
        err_d       = err_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                if (req_valid_i) begin
                    if (req_write_i) begin
                        // Store data doubles as the fill word when the store hits.
                        addr_d      = {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        wdata_d     = req_wdata_i;
                        fill_data_d = req_wdata_i;
                        st_hit_d    = cache_hit_i;
                        state_d     = S_WR;
                    end else if (cache_hit_i) begin
                        if (hit_cnt_q != '1) begin
                            hit_cnt_d = hit_cnt_q + 1'b1;
                        end
                    end else begin
                        if (miss_cnt_q != '1) begin
                            miss_cnt_d = miss_cnt_q + 1'b1;
                        end
                        addr_d      = {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        fill_data_d = '0;
                        state_d     = S_RD;
                    end
                end
            end
            S_RD: begin
                if (mem_ready_i) begin
                    fill_data_d = mem_rdata_i;
                    state_d     = S_FILL;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_FILL;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WR: begin
                if (mem_ready_i) begin
                    state_d = st_hit_q ? S_FILL : S_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_FILL: state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        stall_o      = 1'b0;
        mem_en_o     = 1'b0;
        mem_we_o     = 1'b0;
        fill_valid_o = 1'b0;
        unique case (state_q)
            S_IDLE: stall_o = req_valid_i & (req_write_i | ~cache_hit_i);
            S_RD: begin
                stall_o  = 1'b1;
                mem_en_o = 1'b1;
            end
            S_WR: begin
                stall_o  = 1'b1;
                mem_en_o = 1'b1;
                mem_we_o = 1'b1;
            end
            S_FILL: begin
                stall_o      = 1'b1;
                fill_valid_o = 1'b1;
            end
            S_DONE: stall_o = 1'b0;
            default: stall_o = 1'b0;
        endcase
    end

    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign fill_addr_o = addr_q;
    assign fill_data_o = fill_data_q;
    assign hit_cnt_o   = hit_cnt_q;
    assign miss_cnt_o  = miss_cnt_q;
    assign err_o       = err_q;

endmodule
